// File: rtl/muldiv_pkg.sv
// Shared encodings for the MULT/DIV sequencer: FSM states, op select values, default timing.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WRITE = 2'd2,
        DZERO = 2'd3
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int ITER_DEFAULT  = 32;
    localparam int CNT_W_DEFAULT = 6;

endpackage

// File: rtl/muldiv_iter_cnt.sv
// Iteration counter for the mult/div sequencer: synchronous clear beats enable,
// terminal flag marks the last iteration cycle (count == ITER-1).
module muldiv_iter_cnt #(
    parameter int CNT_W = 6,
    parameter int ITER  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             term
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign term  = (count_q == CNT_W'(ITER - 1));

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the iterative MULT/DIV units and HI/LO writeback; stalls the main
// control unit while busy. All outputs are Moore-decoded from registered state.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int ITER  = ITER_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] operand_b,
    input  logic        abort,
    output logic        mult_start,
    output logic        div_start,
    output logic        multCtrl,
    output logic        divCtrl,
    output logic        HiCtrl,
    output logic        LoCtrl,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    state_t state_q;
    state_t state_d;
    logic   op_q;
    logic   op_d;

    logic [CNT_W-1:0] cnt;
    logic             cnt_term;
    logic             cnt_clr;
    logic             cnt_en;

    // Counter sits at zero outside RUN, so every RUN entry starts from a clean count.
    assign cnt_clr = (state_q != RUN) || abort;
    assign cnt_en  = (state_q == RUN);

    muldiv_iter_cnt #(
        .CNT_W (CNT_W),
        .ITER  (ITER)
    ) u_iter_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cnt),
        .term  (cnt_term)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                // abort outranks starts; MULT outranks DIV when both arrive together
                if (!abort) begin
                    if (start_mult) begin
                        op_d    = OP_MULT;
                        state_d = RUN;
                    end else if (start_div) begin
                        if (operand_b != 32'd0) begin
                            op_d    = OP_DIV;
                            state_d = RUN;
                        end else begin
                            state_d = DZERO;
                        end
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_term) begin
                    state_d = WRITE;
                end
            end
            WRITE:   state_d = IDLE;
            DZERO:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // op_q is held through IDLE so the HI/LO muxes stay on the last result source.
    assign mult_start = (state_q == RUN) && (cnt == '0) && (op_q == OP_MULT);
    assign div_start  = (state_q == RUN) && (cnt == '0) && (op_q == OP_DIV);
    assign multCtrl   = op_q;
    assign divCtrl    = op_q;
    assign HiCtrl     = (state_q == WRITE);
    assign LoCtrl     = (state_q == WRITE);
    assign done       = (state_q == WRITE);
    assign div_zero   = (state_q == DZERO);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected output events are queued as requests are driven
// and matched against what the DUT emits, plus cycle-exact spot checks of busy/selects.
module tb_muldiv_ctrl;

    localparam int EV_MSTART = 1;
    localparam int EV_DSTART = 2;
    localparam int EV_DONE   = 3;
    localparam int EV_DZ     = 4;

    typedef struct {
        int   kind;
        int   cyc;
        logic sel;
    } ev_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] operand_b;
    logic        abort;
    logic        mult_start;
    logic        div_start;
    logic        multCtrl;
    logic        divCtrl;
    logic        HiCtrl;
    logic        LoCtrl;
    logic        busy;
    logic        done;
    logic        div_zero;

    int  cyc     = 0;
    int  n_check = 0;
    int  n_fail  = 0;
    bit  mon_en  = 1'b0;
    ev_t sb[$];

    muldiv_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .operand_b  (operand_b),
        .abort      (abort),
        .mult_start (mult_start),
        .div_start  (div_start),
        .multCtrl   (multCtrl),
        .divCtrl    (divCtrl),
        .HiCtrl     (HiCtrl),
        .LoCtrl     (LoCtrl),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_check++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic sb_push(input int kind, input int at, input logic sel);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        e.sel  = sel;
        sb.push_back(e);
    endtask

    task automatic sb_match(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            check_eq("unexpected_event", kind, 0);
        end else begin
            e = sb.pop_front();
            check_eq("ev_kind", kind, e.kind);
            check_eq("ev_cycle", cyc, e.cyc);
            if (kind == EV_DONE)
                check_eq("done_sel", {multCtrl, divCtrl}, {e.sel, e.sel});
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            check_eq("we_track_done", {HiCtrl, LoCtrl}, {done, done});
            if (mult_start) sb_match(EV_MSTART);
            if (div_start)  sb_match(EV_DSTART);
            if (done)       sb_match(EV_DONE);
            if (div_zero)   sb_match(EV_DZ);
        end
    end

    // Advance to just after the rising edge that begins cycle n.
    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic run_mult(input string tag);
        int c0;
        c0 = cyc;
        start_mult = 1'b1;
        sb_push(EV_MSTART, c0 + 1, 1'b0);
        sb_push(EV_DONE, c0 + 33, 1'b0);
        @(negedge clock);
        check_eq({tag, "_busy_c0"}, busy, 0);
        wait_cyc(c0 + 1);
        start_mult = 1'b0;
        @(negedge clock);
        check_eq({tag, "_busy_c1"}, busy, 1);
        wait_cyc(c0 + 33);
        @(negedge clock);
        check_eq({tag, "_write_c33"}, {busy, HiCtrl, LoCtrl, done}, 4'b1111);
        wait_cyc(c0 + 34);
        @(negedge clock);
        check_eq({tag, "_busy_c34"}, busy, 0);
    endtask

    initial begin
        int c0;
        reset      = 1'b1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        operand_b  = 32'd0;
        abort      = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset  = 1'b0;
        @(negedge clock);
        check_eq("reset_outputs",
                 {mult_start, div_start, multCtrl, divCtrl, HiCtrl, LoCtrl, busy, done, div_zero}, 0);
        mon_en = 1'b1;
        wait_cyc(cyc + 2);

        run_mult("mult");
        wait_cyc(cyc + 2);

        // DIV with nonzero divisor; selects must stay on DIV afterwards in IDLE
        c0 = cyc;
        start_div = 1'b1;
        operand_b = 32'h7;
        sb_push(EV_DSTART, c0 + 1, 1'b1);
        sb_push(EV_DONE, c0 + 33, 1'b1);
        wait_cyc(c0 + 1);
        start_div = 1'b0;
        wait_cyc(c0 + 40);
        @(negedge clock);
        check_eq("div_sel_hold", {multCtrl, divCtrl, busy}, 3'b110);
        wait_cyc(cyc + 1);

        // divide by zero
        c0 = cyc;
        start_div = 1'b1;
        operand_b = 32'h0;
        sb_push(EV_DZ, c0 + 1, 1'b0);
        wait_cyc(c0 + 1);
        start_div = 1'b0;
        @(negedge clock);
        check_eq("dz_busy_c1", {busy, HiCtrl, LoCtrl}, 3'b100);
        wait_cyc(c0 + 2);
        @(negedge clock);
        check_eq("dz_idle_c2", {busy, div_zero}, 2'b00);
        wait_cyc(cyc + 1);

        // simultaneous starts: MULT wins; a DIV request while busy is ignored
        c0 = cyc;
        start_mult = 1'b1;
        start_div  = 1'b1;
        operand_b  = 32'h7;
        sb_push(EV_MSTART, c0 + 1, 1'b0);
        sb_push(EV_DONE, c0 + 33, 1'b0);
        wait_cyc(c0 + 1);
        start_mult = 1'b0;
        start_div  = 1'b0;
        wait_cyc(c0 + 10);
        start_div = 1'b1;
        wait_cyc(c0 + 11);
        start_div = 1'b0;
        wait_cyc(c0 + 36);

        // abort mid-RUN, then a fresh MULT in the first IDLE cycle
        c0 = cyc;
        start_mult = 1'b1;
        sb_push(EV_MSTART, c0 + 1, 1'b0);
        wait_cyc(c0 + 1);
        start_mult = 1'b0;
        wait_cyc(c0 + 15);
        abort = 1'b1;
        wait_cyc(c0 + 16);
        abort      = 1'b0;
        start_mult = 1'b1;
        sb_push(EV_MSTART, c0 + 17, 1'b0);
        sb_push(EV_DONE, c0 + 49, 1'b0);
        @(negedge clock);
        check_eq("abort_idle_c16", busy, 0);
        wait_cyc(c0 + 17);
        start_mult = 1'b0;
        wait_cyc(c0 + 52);

        // abort during WRITE has no effect
        c0 = cyc;
        start_mult = 1'b1;
        sb_push(EV_MSTART, c0 + 1, 1'b0);
        sb_push(EV_DONE, c0 + 33, 1'b0);
        wait_cyc(c0 + 1);
        start_mult = 1'b0;
        wait_cyc(c0 + 33);
        abort = 1'b1;
        wait_cyc(c0 + 34);
        abort = 1'b0;
        @(negedge clock);
        check_eq("abort_write_idle", busy, 0);
        wait_cyc(cyc + 1);

        // abort in IDLE drops a simultaneous start
        c0 = cyc;
        start_mult = 1'b1;
        abort      = 1'b1;
        wait_cyc(c0 + 1);
        start_mult = 1'b0;
        abort      = 1'b0;
        @(negedge clock);
        check_eq("abort_idle_drop", busy, 0);
        wait_cyc(cyc + 3);

        // reset mid-DIV returns everything to zero, then MULT behaves as the first run
        c0 = cyc;
        start_div = 1'b1;
        operand_b = 32'h7;
        sb_push(EV_DSTART, c0 + 1, 1'b1);
        wait_cyc(c0 + 1);
        start_div = 1'b0;
        wait_cyc(c0 + 20);
        reset = 1'b1;
        wait_cyc(c0 + 21);
        reset = 1'b0;
        @(negedge clock);
        check_eq("reset_mid_div",
                 {mult_start, div_start, multCtrl, divCtrl, HiCtrl, LoCtrl, busy, done, div_zero}, 0);
        wait_cyc(cyc + 1);
        run_mult("mult_after_reset");

        wait_cyc(cyc + 45);
        check_eq("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
